atan2_cordic_iter: RTL and testbench

- Inverse of the sin/cos phase-to-amplitude path. It takes a signed Cartesian pair (x, y) in Q2.30 and returns the 32-bit phase atan2(y, x).
- The phase format matches the sin/cos generators: radian / (2*pi) * 2^32.
- Iterative vectoring-mode CORDIC, one micro-rotation per clock, with a valid/ready input handshake and a one-cycle valid_o pulse.
- Used for phase recovery, for example closing a loop around the NCO/sin generator.

---
 rtl/atan2_cordic_pkg.sv | 25 ++
 rtl/cordic_atan_rom.sv | 15 +
 rtl/atan2_cordic_iter.sv | 134 +++++++++++++
 tb/tb_atan2_cordic_iter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/atan2_cordic_pkg.sv
// rtl/atan2_cordic_pkg.sv - shared types and constants for the iterative atan2 CORDIC
package atan2_cordic_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROT, MAG, OUT} state_t;

  localparam int PHASE_W  = 32;
  localparam int IN_W     = 32;
  localparam int INT_GROW = 3;

  // round(atan(2^-i) / (2*pi) * 2^32)
  localparam logic [PHASE_W-1:0] ATAN_TBL [0:30] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001
  };

  // 1/K of the CORDIC gain, unsigned Q0.32
  localparam logic [31:0] CORDIC_KINV = 32'h9B74_EDA8;

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational arctangent lookup by micro-rotation index
module cordic_atan_rom
  import atan2_cordic_pkg::*;
(
  input  logic [4:0]         idx,
  output logic [PHASE_W-1:0] atan
);

  // Index 31 has no table entry and reads as zero
  always_comb begin
    atan = '0;
    if (idx != 5'd31) atan = ATAN_TBL[idx];
  end

endmodule

// File: rtl/atan2_cordic_iter.sv
// rtl/atan2_cordic_iter.sv - iterative vectoring CORDIC atan2; ATAN2_CORDIC_MAG_EN adds mag_o
module atan2_cordic_iter
  import atan2_cordic_pkg::*;
#(
  parameter int ITER  = 24,
  parameter int GUARD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    x_i,
  input  logic [IN_W-1:0]    y_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [PHASE_W-1:0] phase_o,
`ifdef ATAN2_CORDIC_MAG_EN
  output logic [31:0]        mag_o,
`endif
  output logic               valid_o
);

  localparam int         W    = IN_W + INT_GROW + GUARD;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t               state;
  logic [IN_W-1:0]      x_in, y_in;
  logic signed [W-1:0]  x_r, y_r;
  logic signed [W-1:0]  x_ext, y_ext, x_sh, y_sh;
  logic [PHASE_W-1:0]   z_r, atan_v;
  logic [4:0]           iter;
  logic                 zero_f;

  assign ready_o = (state == IDLE);

  // Sign-grow and append guard bits before any negation so -(-2.0) fits
  assign x_ext = {{INT_GROW{x_in[IN_W-1]}}, x_in, {GUARD{1'b0}}};
  assign y_ext = {{INT_GROW{y_in[IN_W-1]}}, y_in, {GUARD{1'b0}}};
  assign x_sh  = x_r >>> iter;
  assign y_sh  = y_r >>> iter;

  cordic_atan_rom u_rom (
    .idx  (iter),
    .atan (atan_v)
  );

`ifdef ATAN2_CORDIC_MAG_EN
  localparam logic [W+31:0] MAG_RND = (W + 32)'(1) << (31 + GUARD);
  logic [W+31:0] mag_prod;
  logic [31:0]   mag_v, mag_q;
  // X is non-negative after vectoring, so it is scaled as unsigned
  assign mag_prod = {32'b0, x_r} * {{W{1'b0}}, CORDIC_KINV};
  assign mag_v    = 32'((mag_prod + MAG_RND) >> (32 + GUARD));
`endif

  // Control FSM and datapath: capture, pre-rotate, iterate, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase_o <= '0;
      valid_o <= 1'b0;
      x_in    <= '0;
      y_in    <= '0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      iter    <= '0;
      zero_f  <= 1'b0;
`ifdef ATAN2_CORDIC_MAG_EN
      mag_o   <= '0;
      mag_q   <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            x_in  <= x_i;
            y_in  <= y_i;
            state <= LOAD;
          end
        end
        LOAD: begin
          zero_f <= (x_in == '0) && (y_in == '0);
          iter   <= '0;
          // Left half-plane: rotate by pi so the iterations only see |angle| <= pi/2
          if (x_in[IN_W-1]) begin
            x_r <= -x_ext;
            y_r <= -y_ext;
            z_r <= 32'h8000_0000;
          end else begin
            x_r <= x_ext;
            y_r <= y_ext;
            z_r <= '0;
          end
          state <= ROT;
        end
        ROT: begin
          if (!y_r[W-1]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_v;
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_v;
          end
          iter <= iter + 5'd1;
          if (iter == LAST) begin
`ifdef ATAN2_CORDIC_MAG_EN
            state <= MAG;
`else
            state <= OUT;
`endif
          end
        end
`ifdef ATAN2_CORDIC_MAG_EN
        MAG: begin
          mag_q <= mag_v;
          state <= OUT;
        end
`endif
        OUT: begin
          phase_o <= zero_f ? '0 : z_r;
          valid_o <= 1'b1;
`ifdef ATAN2_CORDIC_MAG_EN
          mag_o   <= mag_q;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_cordic_iter.sv
// tb/tb_atan2_cordic_iter.sv - scoreboard bench for atan2_cordic_iter
module tb_atan2_cordic_iter;

`ifdef ATAN2_CORDIC_MAG_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 26;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x_i, y_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] phase_o;
  logic        valid_o;
`ifdef ATAN2_CORDIC_MAG_EN
  logic [31:0] mag_o;
`endif

  atan2_cordic_iter dut (
    .clk     (clk),
    .rst     (rst),
    .x_i     (x_i),
    .y_i     (y_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .phase_o (phase_o),
`ifdef ATAN2_CORDIC_MAG_EN
    .mag_o   (mag_o),
`endif
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] phase;
    int          tol;
    int          acc;
    bit          mchk;
  } exp_t;

  exp_t sb[$];
  exp_t mexp;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   pulses = 0;
  int   pushed = 0;
  int   md;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every valid_o pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (valid_o) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_valid_o", phase_o, 0, 1'b0);
      end else begin
        mexp = sb.pop_front();
        md   = $signed(phase_o - mexp.phase);
        chk("phase", phase_o, mexp.phase, (md <= mexp.tol) && (md >= -mexp.tol));
        chk("latency", cyc - mexp.acc, LAT, (cyc - mexp.acc) == LAT);
`ifdef ATAN2_CORDIC_MAG_EN
        if (mexp.mchk) begin
          md = $signed(mag_o - 32'h4000_0000);
          chk("mag", mag_o, 32'h4000_0000, (md <= 256) && (md >= -256));
        end
`endif
      end
    end
  end

  task automatic push(input logic [31:0] p, input int tol, input bit mc);
    sb.push_back('{p, tol, cyc + 1, mc});
    pushed++;
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = ready_o;
    if (!ok) chk("ready_timeout", 0, 1, 1'b0);
  endtask

  // Issue one sample and watch ready_o stay low while busy
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] p, input int tol, input bit mc);
    bit ok;
    bit lo;
    wait_ready(ok);
    if (ok) begin
      x_i = x;
      y_i = y;
      valid_i = 1'b1;
      push(p, tol, mc);
      @(negedge clk);
      valid_i = 1'b0;
      lo = 1'b1;
      for (int k = 0; k < 25; k++) begin
        if (ready_o) lo = 1'b0;
        @(negedge clk);
      end
      chk("ready_low_busy", lo, 1, lo);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int prev_acc;
    int t;

    rst = 1'b1;
    valid_i = 1'b0;
    x_i = '0;
    y_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_phase", phase_o, 0, phase_o == 32'h0);
    chk("reset_valid", valid_o, 0, valid_o == 1'b0);
    chk("reset_ready", ready_o, 1, ready_o == 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Cardinal points, diagonals, atan(1/2), zero and full-scale negative x
    send(32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 64, 1'b1);
    send(32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 64, 1'b1);
    send(32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 64, 1'b1);
    send(32'h0000_0000, 32'hC000_0000, 32'hC000_0000, 64, 1'b1);
    send(32'h4000_0000, 32'hC000_0000, 32'hE000_0000, 64, 1'b0);
    send(32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 64, 1'b0);
    send(32'h4000_0000, 32'h2000_0000, 32'h12E4_051E, 64, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0,  1'b0);
    send(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 64, 1'b0);

    // valid_i held high across three distinct samples
    wait_ready(ok);
    x_i = 32'h4000_0000; y_i = 32'h0000_0000; valid_i = 1'b1;
    push(32'h0000_0000, 64, 1'b1);
    prev_acc = cyc + 1;
    for (int s = 1; s < 3; s++) begin
      @(negedge clk);
      if (s == 1) begin x_i = 32'h0000_0000; y_i = 32'h4000_0000; end
      else        begin x_i = 32'h2000_0000; y_i = 32'h2000_0000; end
      wait_ready(ok);
      if (s == 1) push(32'h4000_0000, 64, 1'b1);
      else        push(32'h2000_0000, 64, 1'b0);
      chk("accept_spacing", cyc + 1 - prev_acc, LAT + 1, (cyc + 1 - prev_acc) == LAT + 1);
      prev_acc = cyc + 1;
    end
    @(negedge clk);
    valid_i = 1'b0;

    // Reset in the middle of a computation discards it
    wait_ready(ok);
    x_i = 32'h4000_0000; y_i = 32'h4000_0000; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready_o, 1, ready_o == 1'b1);
    chk("phase_after_reset", phase_o, 0, phase_o == 32'h0);
    repeat (40) @(negedge clk);
    send(32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 64, 1'b1);

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0, sb.size() == 0);
    repeat (5) @(negedge clk);
    chk("pulse_count", pulses, pushed, pulses == pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
